// File: rtl/spi_peripheral_ht16d35a_if.sv
// 3-wire SPI bus bundle for the HT16D35A-style target model.
//   sck   : bus clock, idles high (controller -> target)
//   cs    : chip select, active low (controller -> target)
//   dio_i : data from controller
//   dio_o : data to controller
//   dio_e : output enable for dio_o
// master = controller side, slave = target side.
interface spi_peripheral_ht16d35a_if;
  logic sck;
  logic cs;
  logic dio_i;
  logic dio_o;
  logic dio_e;

  modport master (output sck, output cs, output dio_i, input dio_o, input dio_e);
  modport slave  (input sck, input cs, input dio_i, output dio_o, output dio_e);
endinterface

// File: rtl/spi_peripheral_ht16d35a.sv
// Target-side model of an HT16D35A-style 3-wire SPI bus.
// The bus pins are oversampled on clk, command and write bytes are
// deserialised, and read bytes are serialised back onto the data line.
//
// Ports:
//   clk, reset    : system clock, asynchronous active-high reset
//   bus (slave)   : sck / cs / dio_i in, dio_o / dio_e out
//   rx_data       : last received byte
//   rx_valid      : one-cycle strobe, rx_data valid
//   rx_first      : with rx_valid, byte is the command byte
//   tx_req        : one-cycle request for the next read byte
//   tx_data       : read byte, sampled on the clk edge after tx_req
//   busy          : frame in progress
//   frame_end     : one-cycle strobe when cs deasserts in a frame
//   frame_partial : with frame_end, the frame ended mid-byte
//   gap_error     : sticky inter-byte timing violation
//
// Optional feature: define SPI_PERIPH_GAP_CHECK_EN to build the inter-byte
// gap checker; otherwise gap_error is tied low.
module spi_peripheral_ht16d35a #(
  parameter int LSB_FIRST   = 0,
  parameter int READ_BIT    = 7,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CLKS    = 100
) (
  input  logic                        clk,
  input  logic                        reset,
  spi_peripheral_ht16d35a_if.slave    bus,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  output logic                        rx_first,
  output logic                        tx_req,
  input  logic [7:0]                  tx_data,
  output logic                        busy,
  output logic                        frame_end,
  output logic                        frame_partial,
  output logic                        gap_error
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WRITE, S_READ, S_WAIT_HIGH} state_t;

  localparam logic [2:0] WARM = 3'(SYNC_STAGES + 1);

  function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b);
    return (LSB_FIRST != 0) ? {b, sr[7:1]} : {sr[6:0], b};
  endfunction

  function automatic logic tx_bit(input logic [7:0] sr);
    return (LSB_FIRST != 0) ? sr[0] : sr[7];
  endfunction

  function automatic logic [7:0] tx_shift(input logic [7:0] sr);
    return (LSB_FIRST != 0) ? {1'b0, sr[7:1]} : {sr[6:0], 1'b0};
  endfunction

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, dio_sync;
  logic                   sck_prev, cs_prev;
  logic [2:0]             warm_p;
  logic                   settled, sck_s, cs_s, dio_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_shreg, tx_shreg, rx_next;
  logic        done_p, done_first_p, done_read_p, fall_p1;
  logic        dio_o_p, dio_e_p;

  // Stage p0: pin synchronisers and edge history. The warm-up counter keeps
  // edge detection off until the chain and history hold real pin values, so
  // a cs held low through reset is not mistaken for a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync <= '1;
      cs_sync  <= '1;
      dio_sync <= '0;
      sck_prev <= 1'b1;
      cs_prev  <= 1'b1;
      warm_p   <= '0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
      dio_sync <= {dio_sync[SYNC_STAGES-2:0], bus.dio_i};
      sck_prev <= sck_sync[SYNC_STAGES-1];
      cs_prev  <= cs_sync[SYNC_STAGES-1];
      if (warm_p != WARM) warm_p <= warm_p + 3'd1;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign dio_s    = dio_sync[SYNC_STAGES-1];
  assign settled  = (warm_p == WARM);
  assign sck_rise = settled &  sck_s & ~sck_prev;
  assign sck_fall = settled & ~sck_s &  sck_prev;
  assign cs_rise  = settled &  cs_s  & ~cs_prev;
  assign cs_fall  = settled & ~cs_s  &  cs_prev;
  assign rx_next  = shift_in(rx_shreg, dio_s);

  assign bus.dio_o = dio_o_p;
  assign bus.dio_e = dio_e_p;

  // Stage p1: frame FSM acting on edge events; byte completion and read-bit
  // requests are flagged here and turned into strobes / pin updates in p2.
  // Stage p2: rx_valid / tx_req strobes, tx latch and dio_o drive.
  // The cs-rise handling is written last so it overrides a pending dio_e set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      bit_cnt       <= '0;
      rx_shreg      <= '0;
      tx_shreg      <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_first      <= 1'b0;
      tx_req        <= 1'b0;
      busy          <= 1'b0;
      frame_end     <= 1'b0;
      frame_partial <= 1'b0;
      done_p        <= 1'b0;
      done_first_p  <= 1'b0;
      done_read_p   <= 1'b0;
      fall_p1       <= 1'b0;
      dio_o_p       <= 1'b0;
      dio_e_p       <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      tx_req       <= 1'b0;
      frame_end    <= 1'b0;
      done_p       <= 1'b0;
      done_first_p <= 1'b0;
      done_read_p  <= 1'b0;
      fall_p1      <= 1'b0;

      if (done_p) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_shreg;
        rx_first <= done_first_p;
      end
      if (done_read_p) tx_req <= 1'b1;

      if (tx_req) begin
        tx_shreg <= tx_data;
      end else if (fall_p1 && state == S_READ) begin
        dio_o_p  <= tx_bit(tx_shreg);
        tx_shreg <= tx_shift(tx_shreg);
        dio_e_p  <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            state   <= S_CMD;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end else if (settled && !cs_s) begin
            state <= S_WAIT_HIGH;
          end
        end
        S_CMD, S_WRITE: begin
          if (!cs_rise && sck_rise) begin
            rx_shreg <= rx_next;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              done_p       <= 1'b1;
              done_first_p <= (state == S_CMD);
              if (state == S_CMD) begin
                if (rx_next[READ_BIT]) begin
                  state       <= S_READ;
                  done_read_p <= 1'b1;
                end else begin
                  state <= S_WRITE;
                end
              end
            end
          end
        end
        S_READ: begin
          if (!cs_rise) begin
            if (sck_fall) fall_p1 <= 1'b1;
            if (sck_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) done_read_p <= 1'b1;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (cs_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (cs_rise && (state == S_CMD || state == S_WRITE || state == S_READ)) begin
        frame_end     <= 1'b1;
        frame_partial <= (bit_cnt != 3'd0);
        dio_e_p       <= 1'b0;
        busy          <= 1'b0;
        state         <= S_IDLE;
      end
    end
  end

`ifdef SPI_PERIPH_GAP_CHECK_EN
  localparam logic [15:0] GAP_LIM = 16'(GAP_CLKS);

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic        active, byte_edge;
  logic [15:0] gap_cnt_p;
  logic        gap_arm_p;

  assign active    = (state == S_CMD) || (state == S_WRITE) || (state == S_READ);
  assign byte_edge = active && sck_rise && !cs_rise && (bit_cnt == 3'd7);

  // Gap checker: counts clk cycles since the last byte's 8th rising edge and
  // flags any falling sck or rising cs that arrives too early.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt_p <= '0;
      gap_arm_p <= 1'b0;
      gap_error <= 1'b0;
    end else if (state == S_IDLE && cs_fall) begin
      gap_cnt_p <= '0;
      gap_arm_p <= 1'b0;
      gap_error <= 1'b0;
    end else begin
      if (byte_edge) begin
        gap_cnt_p <= '0;
        gap_arm_p <= 1'b1;
      end else begin
        gap_cnt_p <= sat_inc(gap_cnt_p);
      end
      if (active && gap_arm_p && (sck_fall || cs_rise) && gap_cnt_p < GAP_LIM)
        gap_error <= 1'b1;
    end
  end
`else
  assign gap_error = 1'b0;
`endif

endmodule

// File: doc/spi_peripheral_ht16d35a.md
# spi_peripheral_ht16d35a

Target-side model of the HT16D35A-style 3-wire SPI bus: samples `sck`/`cs`/`dio_i` from an external controller with system-clock oversampling, deserialises command and write bytes, and serialises read bytes back on the shared data line. It is used as an on-FPGA loopback target for the controller in hardware self-test and as a synthesizable bench responder in simulation. Bytes go out to fabric logic on a strobe interface, and read data comes in on a request/data interface.

## Interface
Parameters:
- `LSB_FIRST`, 0: bit order per byte; 0 = MSB first.
- `READ_BIT`, 7: bit index of the command byte that selects read mode when 1.
- `SYNC_STAGES`, 2: synchroniser depth on `sck`, `cs` and `dio_i`; legal range 2–3.
- `GAP_CLKS`, 100: minimum inter-byte `sck`-high time in `clk` cycles (2 µs at 50 MHz).

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `sck` in 1: bus clock, idles high.
- `cs` in 1: chip select, active low.
- `dio_i` in 1: bus data from controller.
- `dio_o` out 1: bus data to controller.
- `dio_e` out 1: output enable for `dio_o`.
- `rx_data` out 8: last received byte.
- `rx_valid` out 1: one-cycle strobe, `rx_data` valid.
- `rx_first` out 1: qualifies `rx_valid`; byte is the command byte.
- `tx_req` out 1: one-cycle request for next read byte.
- `tx_data` in 8: read byte; latched the cycle after `tx_req`.
- `busy` out 1: frame in progress.
- `frame_end` out 1: one-cycle strobe on `cs` deassert.
- `frame_partial` out 1: qualifies `frame_end`; frame ended mid-byte.
- `gap_error` out 1: sticky inter-byte timing violation.

## Operation
- All three bus inputs pass through `SYNC_STAGES` flops. Edges are detected on the synchronised `sck` and `cs`. All behaviour uses these edge events only.
- States:
  - `S_IDLE`: waits for `cs` to fall.
  - `S_CMD`: receives the command byte.
  - `S_WRITE`: receives write bytes.
  - `S_READ`: transmits read bytes.
  - `S_WAIT_HIGH`: ignores the bus until `cs` is high.
- `S_IDLE`:
  - `cs` falling → `S_CMD`, `bit_cnt=0`, `busy=1`, clear `gap_error`.
  - If `cs` is low when leaving reset → `S_WAIT_HIGH`.
- `S_CMD` and `S_WRITE`:
  - On each `sck` rising edge, shift in synchronised `dio_i` (MSB first unless `LSB_FIRST`) and increment `bit_cnt` (3-bit, wraps 7→0).
  - On the 8th bit, pulse `rx_valid` the next cycle with the full byte; `rx_first=1` only for the byte received in `S_CMD`.
  - From `S_CMD`: if `byte[READ_BIT]` → `S_READ` and pulse `tx_req` in the same cycle as `rx_valid`; else → `S_WRITE`.
- `S_READ`:
  - The cycle after `tx_req`, latch `tx_data` into the shift register.
  - On each `sck` falling edge, drive `dio_o` with the next bit and set `dio_e=1`.
  - Count bits on `sck` rising edges. After the 8th rising edge, pulse `tx_req` and reload for the next byte.
  - `dio_e` stays 1 until the frame ends.
- `cs` rising in any active state:
  - Pulse `frame_end`; `frame_partial=1` if `bit_cnt!=0`.
  - Drop the partial byte (no `rx_valid`).
  - Set `dio_e=0`, `busy=0`, → `S_IDLE`.
  - When `cs` rises in the same cycle as an `sck` edge, `cs` wins and the `sck` edge is ignored.
- `S_WAIT_HIGH`: `cs` high → `S_IDLE`. No strobes are produced.
- Reset values:
  - `dio_o=0`, `dio_e=0`, `rx_data=0`, `rx_valid=0`, `rx_first=0`, `tx_req=0`, `busy=0`, `frame_end=0`, `frame_partial=0`, `gap_error=0`.
  - State → `S_IDLE`, `bit_cnt=0`.
  - Reset mid-frame aborts immediately, with no `frame_end`.

## Timing
- Bus-pin edge → internal event: `SYNC_STAGES`+1 `clk` cycles.
- 8th `sck` rising edge at pin → `rx_valid` high: `SYNC_STAGES`+2 cycles.
- `sck` falling edge at pin → `dio_o`/`dio_e` updated: `SYNC_STAGES`+2 cycles.
- `tx_req` → `tx_data` sampled at the next `clk` edge. Fabric must answer within 1 cycle.
- Required bus timing: `sck` high and low phases ≥ `SYNC_STAGES`+3 `clk` cycles each. `cs` setup to the first `sck` falling edge ≥ same.
- `rx_valid`, `tx_req` and `frame_end` are single-cycle and never back-to-back within a byte.

## Configuration
- `SPI_PERIPH_GAP_CHECK_EN` defined:
  - A 16-bit saturating counter runs from each byte's 8th rising edge.
  - `gap_error` sets if an `sck` falling edge or `cs` rising edge occurs while the counter is < `GAP_CLKS`.
  - `gap_error` holds until the next `cs` falling edge or reset.
- Not defined: the counter is absent and `gap_error` is tied 0.

## Test plan
- Write frame, `cs` low, bytes 0x35 then 0xA5 (MSB first, `sck` period 16 clk, 2 µs gaps) → `rx_valid` twice: 0x35 with `rx_first=1`, then 0xA5 with `rx_first=0`. Then `frame_end=1`, `frame_partial=0`.
- Read frame, command 0x81, `tx_data` answers 0x5C then 0xC3, 16 read clocks → `tx_req` pulses twice. Controller samples 0x5C, 0xC3 on rising edges. `dio_e` is 1 from the first read falling edge until `cs` rises.
- `LSB_FIRST=1`, bus bits sent LSB-first for 0x01 → `rx_data=0x01`.
- `cs` rises after 5 bits of the second byte → no second `rx_valid`; `frame_end=1`, `frame_partial=1`.
- With `SPI_PERIPH_GAP_CHECK_EN`, second byte starts 40 clk after the first → `gap_error=1`, sticky, cleared on the next `cs` fall. Without the macro → `gap_error` stays 0.
- `reset` asserted mid-byte while `cs` stays low → outputs at reset values, no strobes until `cs` goes high then low again.
